mru_tracker: RTL and testbench

Parametrised most-recently-used value tracker: keeps the last `DEPTH` distinct values seen on a data stream, ordered from most to least recent, and reports hit, hit position and eviction for every accepted sample. It is the generalised successor of the fixed 4-entry, 8-bit unique-value shift list. It adds configurable width and depth, an input qualifier, a flush, and hit/eviction side outputs. It sits in-line on a sample stream and feeds downstream statistics logic.

---
 rtl/mru_tracker.sv | 108 ++++++++++
 tb/tb_mru_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mru_tracker.sv
// mru_tracker: keeps the last DEPTH distinct sample values in
// most-recent-first order, reporting hit, hit position and eviction
// for every accepted sample. All outputs are registered.
module mru_tracker #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_valid_in,
  input  logic                    flush_in,
  output logic [DEPTH*DATA_W-1:0] out_data,
  output logic [DEPTH-1:0]        out_valid,
  output logic                    hit_out,
  output logic [IDX_W-1:0]        hit_idx_out,
  output logic [DATA_W-1:0]       evict_out,
  output logic                    evict_valid_out,
  output logic [CNT_W-1:0]        hit_cnt_out
);

  logic [DATA_W-1:0] slot_reg  [DEPTH];
  logic [DATA_W-1:0] slot_next [DEPTH];
  logic [DATA_W-1:0] base_slot [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  base_valid;
  logic [DEPTH-1:0]  match;
  logic [IDX_W-1:0]  hit_pos;
  logic              hit_any;
  logic              is_hit;
  logic              do_evict;

  logic              hit_reg;
  logic [IDX_W-1:0]  hit_idx_reg;
  logic [DATA_W-1:0] evict_reg;
  logic              evict_valid_reg;
  logic [CNT_W-1:0]  hit_cnt_reg;

  // Compare against the registered list only; invalid slots never match,
  // even if they still hold an equal value (e.g. 0 after a flush).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi]     = valid_reg[gi] && (slot_reg[gi] == data_in);
    // A flush empties the list before the sample is applied.
    assign base_slot[gi] = flush_in ? '0 : slot_reg[gi];
    assign out_data[gi*DATA_W +: DATA_W] = slot_reg[gi];
  end

  assign base_valid = flush_in ? '0 : valid_reg;
  assign hit_any    = |match;
  // A sample arriving with a flush lands in an empty list, so it is a miss.
  assign is_hit     = data_valid_in && !flush_in && hit_any;
  assign do_evict   = data_valid_in && !flush_in && !hit_any && valid_reg[DEPTH-1];

  // Encode the matching slot; valid slots are distinct so at most one bit is set.
  always_comb begin
    hit_pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) hit_pos = IDX_W'(k);
    end
  end

  // Next list contents: move-to-front on hit, shift-in on miss, hold when idle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_next
    if (gi == 0) begin : g_head
      assign slot_next[gi] = data_valid_in ? data_in : base_slot[gi];
    end else begin : g_tail
      assign slot_next[gi] = !data_valid_in                        ? base_slot[gi]   :
                             (is_hit && (IDX_W'(gi) > hit_pos))    ? base_slot[gi]   :
                                                                     base_slot[gi-1];
    end
  end

  assign valid_next = !data_valid_in ? base_valid :
                      is_hit         ? valid_reg  :
                                       {base_valid[DEPTH-2:0], 1'b1};

  // List state and side outputs, all updated on the same edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int k = 0; k < DEPTH; k++) slot_reg[k] <= '0;
      valid_reg       <= '0;
      hit_reg         <= 1'b0;
      hit_idx_reg     <= '0;
      evict_reg       <= '0;
      evict_valid_reg <= 1'b0;
      hit_cnt_reg     <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) slot_reg[k] <= slot_next[k];
      valid_reg       <= valid_next;
      hit_reg         <= is_hit;
      hit_idx_reg     <= is_hit ? hit_pos : '0;
      evict_valid_reg <= do_evict;
      if (do_evict) evict_reg <= slot_reg[DEPTH-1];
      if (is_hit && (hit_cnt_reg != {CNT_W{1'b1}})) hit_cnt_reg <= hit_cnt_reg + 1'b1;
    end
  end

  assign out_valid       = valid_reg;
  assign hit_out         = hit_reg;
  assign hit_idx_out     = hit_idx_reg;
  assign evict_out       = evict_reg;
  assign evict_valid_out = evict_valid_reg;
  assign hit_cnt_out     = hit_cnt_reg;

endmodule

// File: tb/tb_mru_tracker.sv
// Directed testbench for mru_tracker (DEPTH=4, DATA_W=8), with a second
// CNT_W=4 instance sharing the stimulus to exercise counter saturation.
module tb_mru_tracker;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [7:0]  data_in;
  logic        data_valid_in;
  logic        flush_in;

  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        hit_out;
  logic [1:0]  hit_idx_out;
  logic [7:0]  evict_out;
  logic        evict_valid_out;
  logic [15:0] hit_cnt_out;

  logic [31:0] s_out_data;
  logic [3:0]  s_out_valid;
  logic        s_hit_out;
  logic [1:0]  s_hit_idx_out;
  logic [7:0]  s_evict_out;
  logic        s_evict_valid_out;
  logic [3:0]  s_hit_cnt_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mru_tracker #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk_in(clk), .reset_in(reset_in), .data_in(data_in),
    .data_valid_in(data_valid_in), .flush_in(flush_in),
    .out_data(out_data), .out_valid(out_valid), .hit_out(hit_out),
    .hit_idx_out(hit_idx_out), .evict_out(evict_out),
    .evict_valid_out(evict_valid_out), .hit_cnt_out(hit_cnt_out)
  );

  mru_tracker #(.DATA_W(8), .DEPTH(4), .CNT_W(4)) dut_sat (
    .clk_in(clk), .reset_in(reset_in), .data_in(data_in),
    .data_valid_in(data_valid_in), .flush_in(flush_in),
    .out_data(s_out_data), .out_valid(s_out_valid), .hit_out(s_hit_out),
    .hit_idx_out(s_hit_idx_out), .evict_out(s_evict_out),
    .evict_valid_out(s_evict_valid_out), .hit_cnt_out(s_hit_cnt_out)
  );

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic rst, input logic dv, input logic fl, input logic [7:0] d);
    reset_in      = rst;
    data_valid_in = dv;
    flush_in      = fl;
    data_in       = d;
    @(posedge clk);
    #1;
    $display("txn rst=%0b dv=%0b fl=%0b d=%0d -> data=%08h val=%04b hit=%0b idx=%0d ev=%0d/%0b cnt=%0d",
             rst, dv, fl, d, out_data, out_valid, hit_out, hit_idx_out,
             evict_out, evict_valid_out, hit_cnt_out);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic sample(input logic [7:0] d);
    step(1'b0, 1'b1, 1'b0, d);
  endtask

  logic [7:0] seq_a [7]  = '{1, 2, 1, 2, 1, 2, 1};
  logic [7:0] seq_b [10] = '{1, 2, 3, 4, 3, 2, 3, 4, 3, 4};
  logic [1:0] idx_b [10] = '{0, 0, 0, 0, 1, 2, 1, 2, 1, 1};
  logic       hit_b [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    reset_in = 1'b1; data_valid_in = 1'b0; flush_in = 1'b0; data_in = '0;

    // Reset state: every output zero.
    do_reset();
    chk("rst_data", out_data, 32'h0);
    chk("rst_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_hit", {31'd0, hit_out}, 32'h0);
    chk("rst_idx", {30'd0, hit_idx_out}, 32'h0);
    chk("rst_evict", {24'd0, evict_out}, 32'h0);
    chk("rst_evv", {31'd0, evict_valid_out}, 32'h0);
    chk("rst_cnt", {16'd0, hit_cnt_out}, 32'h0);

    // Alternating 1,2: five hits at slot 1, never an eviction.
    for (int i = 0; i < 7; i++) begin
      sample(seq_a[i]);
      chk("alt_hit", {31'd0, hit_out}, (i >= 2) ? 32'd1 : 32'd0);
      chk("alt_idx", {30'd0, hit_idx_out}, (i >= 2) ? 32'd1 : 32'd0);
      chk("alt_evv", {31'd0, evict_valid_out}, 32'd0);
    end
    chk("alt_data", out_data, 32'h00000201);
    chk("alt_valid", {28'd0, out_valid}, 32'h3);
    chk("alt_cnt", {16'd0, hit_cnt_out}, 32'd5);

    // Move-to-front pattern with hand-derived hit positions.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sample(seq_b[i]);
      chk("mtf_hit", {31'd0, hit_out}, {31'd0, hit_b[i]});
      chk("mtf_idx", {30'd0, hit_idx_out}, {30'd0, idx_b[i]});
      chk("mtf_evv", {31'd0, evict_valid_out}, 32'd0);
    end
    chk("mtf_data", out_data, 32'h01020304);
    chk("mtf_valid", {28'd0, out_valid}, 32'hF);
    chk("mtf_cnt", {16'd0, hit_cnt_out}, 32'd6);

    // Zero is an ordinary value; empty slots holding 0 must not match.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sample(8'd0);
      chk("zero_hit", {31'd0, hit_out}, (i == 0) ? 32'd0 : 32'd1);
    end
    chk("zero_data", out_data, 32'h0);
    chk("zero_valid", {28'd0, out_valid}, 32'h1);
    chk("zero_cnt", {16'd0, hit_cnt_out}, 32'd6);

    // Fill, then evict on the fifth distinct value.
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      sample(8'(i));
      chk("fill_evv", {31'd0, evict_valid_out}, 32'd0);
    end
    sample(8'd5);
    chk("ev_data", out_data, 32'h02030405);
    chk("ev_out", {24'd0, evict_out}, 32'd1);
    chk("ev_valid", {31'd0, evict_valid_out}, 32'd1);
    chk("ev_hit", {31'd0, hit_out}, 32'd0);
    // Hit on the last slot: rotate, no eviction, pulse drops.
    sample(8'd2);
    chk("rot_data", out_data, 32'h03040502);
    chk("rot_hit", {31'd0, hit_out}, 32'd1);
    chk("rot_idx", {30'd0, hit_idx_out}, 32'd3);
    chk("rot_evv", {31'd0, evict_valid_out}, 32'd0);
    chk("rot_evout", {24'd0, evict_out}, 32'd1);
    chk("rot_valid", {28'd0, out_valid}, 32'hF);

    // Flush with a sample on a full list: empty list then miss, counter kept.
    step(1'b0, 1'b1, 1'b1, 8'd9);
    chk("fl_data", out_data, 32'h00000009);
    chk("fl_valid", {28'd0, out_valid}, 32'h1);
    chk("fl_hit", {31'd0, hit_out}, 32'd0);
    chk("fl_evv", {31'd0, evict_valid_out}, 32'd0);
    chk("fl_cnt", {16'd0, hit_cnt_out}, 32'd1);
    // Hit on slot 0 leaves the list unchanged.
    sample(8'd9);
    chk("h0_hit", {31'd0, hit_out}, 32'd1);
    chk("h0_idx", {30'd0, hit_idx_out}, 32'd0);
    chk("h0_data", out_data, 32'h00000009);
    chk("h0_cnt", {16'd0, hit_cnt_out}, 32'd2);
    // Idle cycles: everything holds, pulses low.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd9);
      chk("idle_hit", {31'd0, hit_out}, 32'd0);
      chk("idle_idx", {30'd0, hit_idx_out}, 32'd0);
      chk("idle_evv", {31'd0, evict_valid_out}, 32'd0);
      chk("idle_evout", {24'd0, evict_out}, 32'd1);
      chk("idle_data", out_data, 32'h00000009);
      chk("idle_valid", {28'd0, out_valid}, 32'h1);
      chk("idle_cnt", {16'd0, hit_cnt_out}, 32'd2);
    end

    // Flush without a sample empties the list.
    step(1'b0, 1'b0, 1'b1, 8'd9);
    chk("flo_data", out_data, 32'h0);
    chk("flo_valid", {28'd0, out_valid}, 32'h0);
    chk("flo_cnt", {16'd0, hit_cnt_out}, 32'd2);

    // Reset mid-stream discards the sample on that edge.
    sample(8'd7);
    sample(8'd8);
    step(1'b1, 1'b1, 1'b0, 8'd7);
    chk("mrst_data", out_data, 32'h0);
    chk("mrst_valid", {28'd0, out_valid}, 32'h0);
    chk("mrst_cnt", {16'd0, hit_cnt_out}, 32'd0);
    sample(8'd7);
    chk("post_hit", {31'd0, hit_out}, 32'd0);
    chk("post_data", out_data, 32'h00000007);
    chk("post_valid", {28'd0, out_valid}, 32'h1);

    // Twenty hits: the 4-bit counter saturates at 15, the 16-bit one does not.
    for (int i = 0; i < 20; i++) sample(8'd7);
    chk("sat_cnt4", {28'd0, s_hit_cnt_out}, 32'd15);
    chk("sat_cnt16", {16'd0, hit_cnt_out}, 32'd20);
    chk("sat_data4", s_out_data, 32'h00000007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
